// File: rtl/spi_word_packer.sv
// Packs LSB-first SPI bytes into 24-bit words and tracks downstream FIFO occupancy.
// Define PACKER_CHECKSUM_EN to append and verify a fourth checksum byte per word.
module spi_word_packer #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_12mhz,
   input  logic        rst_sync,
   input  logic        byte_wr,
   input  logic [7:0]  byte_data,
   input  logic        xfer_done,
   input  logic        word_pop,
   input  logic        clear,
   output logic [23:0] word_out,
   output logic        word_wr,
   output logic [7:0]  fifo_level,
   output logic        overflow,
   output logic        partial_err,
   output logic        chk_err
);

   typedef enum logic [2:0] {
      B0,
      B1,
      B2,
`ifdef PACKER_CHECKSUM_EN
      B3,
`endif
      PUSH
   } state_t;

   localparam logic [7:0] DEPTH = 8'(FIFO_DEPTH);

   state_t      state;
   logic [7:0]  byte0, byte1;
   logic [7:0]  level_next;
   logic        full_next;
   logic        push_req;
   logic [23:0] push_word;
`ifdef PACKER_CHECKSUM_EN
   logic [7:0]  byte2;
   logic        chk_fail;
   logic        chk_err_q;
`endif

   // Level as it will read during the next cycle, so a word entering PUSH sees the right fullness.
   always_comb begin
      level_next = fifo_level;
      if (word_wr && !word_pop)
         level_next = fifo_level + 8'd1;
      else if (word_pop && !word_wr && fifo_level != 8'd0)
         level_next = fifo_level - 8'd1;
   end

   assign full_next = (level_next == DEPTH);

`ifdef PACKER_CHECKSUM_EN
   assign push_word = {byte2, byte1, byte0};
   assign push_req  = (state == B3) && byte_wr && (byte_data == (byte0 ^ byte1 ^ byte2 ^ 8'hA5));
   assign chk_fail  = (state == B3) && byte_wr && !push_req;
   assign chk_err   = chk_err_q;
`else
   assign push_word = {byte_data, byte1, byte0};
   assign push_req  = (state == B2) && byte_wr;
   assign chk_err   = 1'b0;
`endif

   // NOTE: payload bytes carry no reset; the FSM never forwards them until all have been rewritten.
   always_ff @(posedge clk_12mhz) begin
      if (byte_wr && (state == B0 || state == PUSH)) byte0 <= byte_data;
      if (byte_wr && state == B1)                    byte1 <= byte_data;
`ifdef PACKER_CHECKSUM_EN
      if (byte_wr && state == B2)                    byte2 <= byte_data;
`endif
   end

   // NOTE: every control register uses non-blocking assignment so all updates see pre-edge values.
   always_ff @(posedge clk_12mhz or posedge rst_sync) begin
      if (rst_sync) begin
         state       <= B0;
         word_out    <= '0;
         word_wr     <= 1'b0;
         fifo_level  <= '0;
         overflow    <= 1'b0;
         partial_err <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
         chk_err_q   <= 1'b0;
`endif
      end else if (clear) begin
         state       <= B0;
         word_wr     <= 1'b0;
         fifo_level  <= '0;
         overflow    <= 1'b0;
         partial_err <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
         chk_err_q   <= 1'b0;
`endif
      end else begin
         fifo_level <= level_next;
         word_wr    <= 1'b0;
         if (push_req) begin
            state <= PUSH;
            if (full_next) begin
               overflow <= 1'b1;
            end else begin
               word_wr  <= 1'b1;
               word_out <= push_word;
            end
         end else begin
            case (state)
               B0, PUSH: begin
                  // A byte here always opens a new word; a coincident xfer_done orphans it.
                  if (byte_wr && xfer_done) begin
                     partial_err <= 1'b1;
                     state       <= B0;
                  end else if (byte_wr) begin
                     state <= B1;
                  end else begin
                     state <= B0;
                  end
               end
               B1: begin
                  if (xfer_done) begin
                     partial_err <= 1'b1;
                     state       <= B0;
                  end else if (byte_wr) begin
                     state <= B2;
                  end
               end
               B2: begin
                  if (xfer_done) begin
                     partial_err <= 1'b1;
                     state       <= B0;
                  end
`ifdef PACKER_CHECKSUM_EN
                  else if (byte_wr) begin
                     state <= B3;
                  end
`endif
               end
`ifdef PACKER_CHECKSUM_EN
               B3: begin
                  if (chk_fail) begin
                     chk_err_q <= 1'b1;
                     state     <= B0;
                  end else if (xfer_done) begin
                     partial_err <= 1'b1;
                     state       <= B0;
                  end
               end
`endif
               default: state <= B0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_word_packer.sv
// Directed bench for spi_word_packer: a queue scoreboard checks every word_wr pulse,
// immediate assertions check levels and flags at each step.
module tb_spi_word_packer;

   logic        clk_12mhz = 1'b0;
   logic        rst_sync  = 1'b1;
   logic        byte_wr   = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        xfer_done = 1'b0;
   logic        word_pop  = 1'b0;
   logic        clear     = 1'b0;
   logic [23:0] word_out;
   logic        word_wr;
   logic [7:0]  fifo_level;
   logic        overflow;
   logic        partial_err;
   logic        chk_err;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [23:0] sb[$];

   spi_word_packer #(.FIFO_DEPTH(16)) dut (
      .clk_12mhz  (clk_12mhz),
      .rst_sync   (rst_sync),
      .byte_wr    (byte_wr),
      .byte_data  (byte_data),
      .xfer_done  (xfer_done),
      .word_pop   (word_pop),
      .clear      (clear),
      .word_out   (word_out),
      .word_wr    (word_wr),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .partial_err(partial_err),
      .chk_err    (chk_err)
   );

   always #42 clk_12mhz = ~clk_12mhz;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard side: every word_wr pulse must match the oldest expected word.
   always @(negedge clk_12mhz) begin
      if (!rst_sync && word_wr === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_word_wr: observed word %0h expected no push", word_out);
         end else begin
            check("word_out", {8'h00, word_out}, {8'h00, sb.pop_front()});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_12mhz);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit done);
      byte_wr   = 1'b1;
      byte_data = b;
      xfer_done = done;
      @(posedge clk_12mhz);
      #1;
      byte_wr   = 1'b0;
      xfer_done = 1'b0;
   endtask

   task automatic send_word(input logic [23:0] w, input bit expect_push, input bit done_last);
      if (expect_push) sb.push_back(w);
`ifdef PACKER_CHECKSUM_EN
      send_byte(w[7:0], 1'b0);
      send_byte(w[15:8], 1'b0);
      send_byte(w[23:16], 1'b0);
      send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ 8'hA5, done_last);
`else
      send_byte(w[7:0], 1'b0);
      send_byte(w[15:8], 1'b0);
      send_byte(w[23:16], done_last);
`endif
   endtask

   task automatic pulse_pop();
      word_pop = 1'b1;
      idle(1);
      word_pop = 1'b0;
   endtask

   initial begin
      idle(3);
      rst_sync = 1'b0;
      check("rst_word_out", {8'h00, word_out}, 32'h0);
      check("rst_word_wr", {31'd0, word_wr}, 32'd0);
      check("rst_level", {24'd0, fifo_level}, 32'd0);
      check("rst_flags", {29'd0, overflow, partial_err, chk_err}, 32'd0);

      // First word: one pulse one cycle after the last byte, then level 1.
      send_word(24'h123456, 1'b1, 1'b0);
      check("push_word_wr", {31'd0, word_wr}, 32'd1);
      check("push_word_out", {8'h00, word_out}, 32'h123456);
      idle(1);
      check("post_push_word_wr", {31'd0, word_wr}, 32'd0);
      check("hold_word_out", {8'h00, word_out}, 32'h123456);
      check("level_1", {24'd0, fifo_level}, 32'd1);

      // Fill to 16 with back-to-back words, then a 17th is dropped.
      for (int i = 1; i < 16; i++) send_word(24'h100000 + 24'(i), 1'b1, 1'b0);
      idle(1);
      check("level_full", {24'd0, fifo_level}, 32'd16);
      check("no_overflow_yet", {31'd0, overflow}, 32'd0);
      send_word(24'hDEAD01, 1'b0, 1'b0);
      idle(2);
      check("overflow_set", {31'd0, overflow}, 32'd1);
      check("level_stays_full", {24'd0, fifo_level}, 32'd16);
      check("dropped_word_not_shown", {8'h00, word_out}, 32'h10000F);
      check("sb_drained_fill", sb.size(), 32'd0);

      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      check("clear_level", {24'd0, fifo_level}, 32'd0);
      check("clear_overflow", {31'd0, overflow}, 32'd0);

      // Aborted partial word, then a clean word.
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      xfer_done = 1'b1;
      idle(1);
      xfer_done = 1'b0;
      idle(1);
      check("partial_err_set", {31'd0, partial_err}, 32'd1);
      check("partial_level", {24'd0, fifo_level}, 32'd0);
      send_word(24'h030201, 1'b1, 1'b0);
      idle(1);
      check("after_partial_level", {24'd0, fifo_level}, 32'd1);
      check("after_partial_word", {8'h00, word_out}, 32'h030201);

      // Push and pop in the same cycle at level 5.
      for (int i = 0; i < 4; i++) send_word(24'h200000 + 24'(i), 1'b1, 1'b0);
      idle(1);
      check("level_5", {24'd0, fifo_level}, 32'd5);
      send_word(24'h2000AA, 1'b1, 1'b0);
      pulse_pop();
      check("push_pop_level", {24'd0, fifo_level}, 32'd5);
      pulse_pop();
      check("pop_level_4", {24'd0, fifo_level}, 32'd4);
      repeat (4) pulse_pop();
      check("pop_level_0", {24'd0, fifo_level}, 32'd0);
      pulse_pop();
      check("pop_at_zero", {24'd0, fifo_level}, 32'd0);

      // Reset mid-word discards the partial word and clears everything.
      send_word(24'h445566, 1'b1, 1'b0);
      idle(1);
      send_byte(8'hC1, 1'b0);
      send_byte(8'hC2, 1'b0);
      rst_sync = 1'b1;
      #1;
      check("mid_rst_word_out", {8'h00, word_out}, 32'h0);
      check("mid_rst_level", {24'd0, fifo_level}, 32'd0);
      check("mid_rst_flags", {28'd0, word_wr, overflow, partial_err, chk_err}, 32'd0);
      idle(2);
      rst_sync = 1'b0;
      send_word(24'h0A0B0C, 1'b1, 1'b0);
      idle(1);
      check("post_rst_level", {24'd0, fifo_level}, 32'd1);

      // Completing byte arrives with xfer_done: pushed, no partial error.
      send_word(24'h777888, 1'b1, 1'b1);
      idle(1);
      check("done_with_last_level", {24'd0, fifo_level}, 32'd2);
      check("done_with_last_no_err", {31'd0, partial_err}, 32'd0);

`ifdef PACKER_CHECKSUM_EN
      sb.push_back(24'h332211);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'hA5, 1'b0);
      idle(1);
      check("chk_ok_level", {24'd0, fifo_level}, 32'd3);
      check("chk_ok_err", {31'd0, chk_err}, 32'd0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h00, 1'b0);
      idle(2);
      check("chk_bad_err", {31'd0, chk_err}, 32'd1);
      check("chk_bad_level", {24'd0, fifo_level}, 32'd3);
`else
      check("chk_err_tied", {31'd0, chk_err}, 32'd0);
`endif

      idle(2);
      check("sb_drained_end", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
